// File: rtl/gauss_window_sequencer_if.sv
// Control/status bundle between the Gaussian window sequencer and the frame controller / filter.
interface gauss_window_sequencer_if #(
  parameter int unsigned WIDTH = 640,
  parameter int unsigned DEPTH = 512
);
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(DEPTH);

  logic             frame_go;
  logic             pix_valid;
  logic             filt_ready;
  logic             filt_start;
  logic             filt_clken;
  logic             filt_hold;
  logic             busy;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             out_last;
  logic             frame_done;
  logic             err_overrun;
  logic             err_underrun;

  modport master (
    output frame_go, pix_valid, filt_ready,
    input  filt_start, filt_clken, filt_hold, busy, out_col, out_row,
           out_last, frame_done, err_overrun, err_underrun
  );

  modport slave (
    input  frame_go, pix_valid, filt_ready,
    output filt_start, filt_clken, filt_hold, busy, out_col, out_row,
           out_last, frame_done, err_overrun, err_underrun
  );
endinterface

// File: rtl/gauss_window_sequencer.sv
// Frame controller for the 3x3 Gaussian stage: gates the filter to full windows,
// indexes its outputs, and reports completion and protocol errors.
module gauss_window_sequencer #(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned FILT_LATENCY = 2,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gauss_window_sequencer_if.slave bus
);

  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(DEPTH);
  localparam int unsigned HALO  = KERNEL_SIZE - 1;
  // Never time out before a correctly timed final ready could have arrived.
  localparam int unsigned DRAIN_LIMIT = (TIMEOUT > FILT_LATENCY) ? TIMEOUT : FILT_LATENCY + 1;
  localparam int unsigned TO_W  = $clog2(DRAIN_LIMIT + 1);

  localparam logic [COL_W-1:0] PIX_COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] PIX_ROW_LAST   = ROW_W'(DEPTH - 1);
  localparam logic [COL_W-1:0] OUT_COL_LAST   = COL_W'(WIDTH - KERNEL_SIZE);
  localparam logic [ROW_W-1:0] OUT_ROW_LAST   = ROW_W'(DEPTH - KERNEL_SIZE);
  localparam logic [COL_W-1:0] HALO_COL       = COL_W'(HALO);
  localparam logic [ROW_W-1:0] HALO_ROW       = ROW_W'(HALO);
  localparam logic [ROW_W-1:0] PRIME_ROW_LAST = ROW_W'(HALO - 1);
  localparam logic [TO_W-1:0]  TO_LAST        = TO_W'(DRAIN_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic [TO_W-1:0]  to_cnt;
  logic             last_issued;

  logic frame_start, pix_acc, clken_nx, out_adv, ovr_set, unr_set, out_last_c;
  logic active, pix_eol, at_last;

  assign active  = (state == S_PRIME) || (state == S_RUN) || (state == S_DRAIN);
  assign pix_eol = (pix_col == PIX_COL_LAST);
  assign at_last = (bus.out_col == OUT_COL_LAST) && (bus.out_row == OUT_ROW_LAST);

  assign bus.out_last = out_last_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state plus per-cycle strobes consumed by the datapath registers.
  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    pix_acc     = 1'b0;
    clken_nx    = 1'b0;
    out_adv     = 1'b0;
    ovr_set     = 1'b0;
    unr_set     = 1'b0;
    out_last_c  = 1'b0;

    if (bus.filt_ready) begin
      if (last_issued) begin
        ovr_set = 1'b1;
      end else if (active) begin
        out_adv    = 1'b1;
        out_last_c = at_last;
      end
    end

    case (state)
      S_IDLE: begin
        if (bus.pix_valid) ovr_set = 1'b1;
        if (bus.frame_go) begin
          frame_start = 1'b1;
          state_nx    = S_PRIME;
        end
      end
      S_PRIME: begin
        if (bus.pix_valid) begin
          pix_acc = 1'b1;
          if (pix_row == PRIME_ROW_LAST && pix_eol) state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.pix_valid) begin
          pix_acc  = 1'b1;
          clken_nx = (pix_row >= HALO_ROW) && (pix_col >= HALO_COL);
          if (pix_row == PIX_ROW_LAST && pix_eol) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.pix_valid) ovr_set = 1'b1;
        if (last_issued || out_last_c) begin
          state_nx = S_DONE;
        end else if (!bus.filt_ready && to_cnt == TO_LAST) begin
          unr_set  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.pix_valid) ovr_set = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Input raster, output index and drain-timeout counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_col     <= '0;
      pix_row     <= '0;
      bus.out_col <= '0;
      bus.out_row <= '0;
      last_issued <= 1'b0;
      to_cnt      <= '0;
    end else begin
      if (frame_start) begin
        pix_col     <= '0;
        pix_row     <= '0;
        bus.out_col <= '0;
        bus.out_row <= '0;
        last_issued <= 1'b0;
      end else begin
        if (pix_acc) begin
          if (pix_eol) begin
            pix_col <= '0;
            pix_row <= (pix_row == PIX_ROW_LAST) ? '0 : pix_row + ROW_W'(1);
          end else begin
            pix_col <= pix_col + COL_W'(1);
          end
        end
        if (out_adv) begin
          if (at_last) begin
            last_issued <= 1'b1;
          end else if (bus.out_col == OUT_COL_LAST) begin
            bus.out_col <= '0;
            bus.out_row <= bus.out_row + ROW_W'(1);
          end else begin
            bus.out_col <= bus.out_col + COL_W'(1);
          end
        end
      end
      if (state != S_DRAIN || bus.filt_ready) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Registered control/status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.filt_start   <= 1'b0;
      bus.filt_clken   <= 1'b0;
      bus.filt_hold    <= 1'b1;
      bus.busy         <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.err_overrun  <= 1'b0;
      bus.err_underrun <= 1'b0;
    end else begin
      bus.filt_start   <= (state_nx == S_PRIME) || (state_nx == S_RUN) || (state_nx == S_DRAIN);
      bus.filt_clken   <= clken_nx;
      bus.filt_hold    <= !((state_nx == S_RUN) || (state_nx == S_DRAIN));
      bus.busy         <= (state_nx != S_IDLE);
      bus.frame_done   <= (state_nx == S_DONE);
      bus.err_overrun  <= (bus.err_overrun & ~frame_start) | ovr_set;
      bus.err_underrun <= (bus.err_underrun & ~frame_start) | unr_set;
    end
  end

endmodule

// File: tb/tb_gauss_window_sequencer.sv
// Directed bench for gauss_window_sequencer on a 5x4 frame with a 2-cycle filter model.
module tb_gauss_window_sequencer;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned DEPTH = 4;
  localparam int LAST_ORD = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gauss_window_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  gauss_window_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .KERNEL_SIZE(3), .FILT_LATENCY(2), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk, n_pass;
  int cyc, p0, p1, clk_ord, prev_pos;
  bit drop_last, in_frame;
  int clk_log[$];
  int rdy_log[$];
  int last_cnt, last_pos, done_cnt, done_cyc, last_rdy_cyc, busy_gap, ctl_bad;
  int exp_clk[6];
  int exp_rdy[6];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One clock: filter model, drive inputs, sample at negedge. Positions are encoded row*8+col.
  task automatic step(input logic pv, input int r, input int c, input logic go, input logic xr);
    int ord;
    if (bus.filt_clken) begin
      clk_ord++;
      ord = clk_ord;
    end else begin
      ord = 0;
    end
    bus.filt_ready = xr || (p1 != 0 && !(drop_last && p1 == LAST_ORD));
    p1 = p0;
    p0 = ord;
    bus.pix_valid = pv;
    bus.frame_go  = go;
    @(negedge clk);
    if (bus.filt_clken) clk_log.push_back(prev_pos);
    prev_pos = pv ? r * 8 + c : -1;
    if (bus.filt_ready) begin
      rdy_log.push_back(int'(bus.out_row) * 8 + int'(bus.out_col));
      last_rdy_cyc = cyc;
      if (in_frame && (!bus.filt_start || bus.filt_hold)) ctl_bad++;
    end
    if (bus.out_last) begin
      last_cnt++;
      last_pos = int'(bus.out_row) * 8 + int'(bus.out_col);
    end
    if (in_frame && !bus.busy) busy_gap++;
    if (bus.frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      in_frame = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ctrl"}, int'({bus.filt_start, bus.filt_clken, bus.filt_hold, bus.busy,
                                bus.frame_done, bus.err_overrun, bus.err_underrun, bus.out_last}),
          int'(8'b0010_0000));
    check({tag, " out_col"}, int'(bus.out_col), 0);
    check({tag, " out_row"}, int'(bus.out_row), 0);
  endtask

  task automatic do_reset();
    check("pre-reset clken pending", int'(bus.filt_clken), 1);
    rst_n = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.frame_go   = 1'b0;
    bus.filt_ready = 1'b0;
    p0 = 0;
    p1 = 0;
    in_frame = 1'b0;
    @(negedge clk);
    check_reset("mid-run reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit gaps, input bit go_mid, input bit drop, input bit abort);
    clk_log.delete();
    rdy_log.delete();
    last_cnt = 0; last_pos = -1; done_cnt = 0; done_cyc = -100; last_rdy_cyc = 0;
    busy_gap = 0; ctl_bad = 0; clk_ord = 0; p0 = 0; p1 = 0; prev_pos = -1;
    drop_last = drop;
    step(1'b0, 0, 0, 1'b1, 1'b0);
    in_frame = 1'b1;
    for (int r = 0; r < int'(DEPTH); r++) begin
      for (int c = 0; c < int'(WIDTH); c++) begin
        if (gaps && $urandom_range(0, 1) == 1) step(1'b0, 0, 0, 1'b0, 1'b0);
        if (go_mid && r == 2 && c == 1) step(1'b0, 0, 0, 1'b1, 1'b0);
        if (abort && r == 3 && c == 0) begin
          do_reset();
          return;
        end
        step(1'b1, r, c, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 40 && done_cnt == 0; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input bit dropped);
    int n_rdy;
    n_rdy = dropped ? 5 : 6;
    check({tag, " clken count"}, clk_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s clken[%0d]", tag, i), (i < clk_log.size()) ? clk_log[i] : -1, exp_clk[i]);
    check({tag, " ready count"}, rdy_log.size(), n_rdy);
    for (int i = 0; i < n_rdy; i++)
      check($sformatf("%s out_idx[%0d]", tag, i), (i < rdy_log.size()) ? rdy_log[i] : -1, exp_rdy[i]);
    check({tag, " out_last count"}, last_cnt, dropped ? 0 : 1);
    if (!dropped) check({tag, " out_last idx"}, last_pos, 10);
    check({tag, " frame_done count"}, done_cnt, 1);
    check({tag, " done delay"}, done_cyc - last_rdy_cyc, dropped ? 9 : 1);
    check({tag, " busy gaps"}, busy_gap, 0);
    check({tag, " start/hold at ready"}, ctl_bad, 0);
    check({tag, " err_overrun"}, int'(bus.err_overrun), 0);
    check({tag, " err_underrun"}, int'(bus.err_underrun), dropped ? 1 : 0);
    check({tag, " idle ctrl"}, int'({bus.busy, bus.filt_start, bus.filt_hold}), int'(3'b001));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; in_frame = 1'b0; drop_last = 1'b0;
    bus.frame_go = 1'b0; bus.pix_valid = 1'b0; bus.filt_ready = 1'b0;
    exp_clk = '{18, 19, 20, 26, 27, 28};
    exp_rdy = '{0, 1, 2, 8, 9, 10};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("power-on reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("plain", 1'b0);

    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check_frame("gapped", 1'b0);

    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check_frame("go mid-run", 1'b0);

    step(1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    check("idle pixel err_overrun", int'(bus.err_overrun), 1);
    check("idle pixel busy", int'(bus.busy), 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("after idle pixel", 1'b0);

    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    check("late ready err_overrun", int'(bus.err_overrun), 1);

    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("dropped ready", 1'b1);

    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("after underrun", 1'b0);

    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("after reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
